// File: rtl/gtxe2_chnl_cpll_refsel_ctrl_pkg.sv
// Shared constants for the CPLL reference-clock select controller.
// Holds FSM state codes, default parameters and the reserved select code.
package gtxe2_chnl_cpll_refsel_ctrl_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CHECK    = 3'd1;
    localparam logic [2:0] ST_GATE_OFF = 3'd2;
    localparam logic [2:0] ST_SWITCH   = 3'd3;
    localparam logic [2:0] ST_SETTLE   = 3'd4;
    localparam logic [2:0] ST_PLL_RST  = 3'd5;

    // Default parameter values
    localparam int DEF_NUM_SRC      = 8;
    localparam int DEF_SEL_W        = 3;
    localparam int DEF_RESERVED0    = 1;
    localparam int DEF_INIT_SEL     = 1;
    localparam int DEF_ACT_WIN      = 64;
    localparam int DEF_GATE_CYC     = 8;
    localparam int DEF_RST_CYC      = 16;
    localparam int DEF_FAILOVER_SEL = 2;

    // Select code that the refclk mux treats as reserved when RESERVED0=1
    localparam int REFSEL_RSVD_CODE = 0;

endpackage

// File: rtl/gtxe2_chnl_clk_activity.sv
// Activity detector for one raw reference clock: 2-flop sync, rising-edge
// detect and a sticky seen flag cleared at window end.
// Ports: clk_i, rst_i (async, high), refclk_i (sampled), win_end_i,
//        act_o = seen-in-window OR edge-this-cycle.
module gtxe2_chnl_clk_activity
    import gtxe2_chnl_cpll_refsel_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic refclk_i,
    input  logic win_end_i,
    output logic act_o
);

    // [0],[1] are the synchronizer; [2] is the edge-detect history
    logic [2:0] sync_q;
    logic       seen_q;
    logic       edge_w;

    assign edge_w = sync_q[1] & ~sync_q[2];
    assign act_o  = seen_q | edge_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            seen_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], refclk_i};
            seen_q <= win_end_i ? 1'b0 : (seen_q | edge_w);
        end
    end

endmodule

// File: rtl/gtxe2_chnl_cpll_refsel_ctrl.sv
// CPLL reference-clock select controller: monitors source activity, and
// sequences gate-off / switch / settle / CPLL reset on each select change.
// Ports: clk_i, rst_i (async, high), refclk_in_i[NUM_SRC], sel_req_i,
//        sel_stb_i; sel_cur_o, mux_gate_o, pll_rst_o, busy_o,
//        src_active_o, err_dead_o, sw_done_o.
// Macro CPLL_REFSEL_FAILOVER_EN adds FAILOVER_SEL and failover_o: loss of
// the current source in IDLE triggers an automatic switch to FAILOVER_SEL.
module gtxe2_chnl_cpll_refsel_ctrl
    import gtxe2_chnl_cpll_refsel_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int RESERVED0 = DEF_RESERVED0,
    parameter int INIT_SEL  = DEF_INIT_SEL,
    parameter int ACT_WIN   = DEF_ACT_WIN,
    parameter int GATE_CYC  = DEF_GATE_CYC,
    parameter int RST_CYC   = DEF_RST_CYC
`ifdef CPLL_REFSEL_FAILOVER_EN
    , parameter int FAILOVER_SEL = DEF_FAILOVER_SEL
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] refclk_in_i,
    input  logic [SEL_W-1:0]   sel_req_i,
    input  logic               sel_stb_i,
    output logic [SEL_W-1:0]   sel_cur_o,
    output logic               mux_gate_o,
    output logic               pll_rst_o,
    output logic               busy_o,
    output logic [NUM_SRC-1:0] src_active_o,
    output logic               err_dead_o,
    output logic               sw_done_o
`ifdef CPLL_REFSEL_FAILOVER_EN
    , output logic             failover_o
`endif
);

    localparam int WIN_W   = $clog2(ACT_WIN);
    localparam int CNT_MAX = (GATE_CYC > RST_CYC) ? GATE_CYC : RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // ---------------- activity detection ----------------
    logic [WIN_W-1:0]   win_q;
    logic               win_end;
    logic [NUM_SRC-1:0] act_vec;
    logic [NUM_SRC-1:0] act_m;
    logic [NUM_SRC-1:0] src_active_q;

    assign win_end = (win_q == WIN_W'(ACT_WIN - 1));

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_act
        gtxe2_chnl_clk_activity u_act (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .refclk_i  (refclk_in_i[g]),
            .win_end_i (win_end),
            .act_o     (act_vec[g])
        );
    end

    always_comb begin
        act_m = act_vec;
        if (RESERVED0 != 0) act_m[REFSEL_RSVD_CODE] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q        <= '0;
            src_active_q <= '0;
        end else begin
            win_q <= win_end ? '0 : win_q + 1'b1;
            if (win_end) src_active_q <= act_m;
        end
    end

    // ---------------- sequencer ----------------
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] req_q, req_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             gate_q, gate_d;
    logic             prst_q, prst_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             req_act;

    // Out-of-range requests never match a source, so they read inactive
    always_comb begin
        req_act = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (req_q == SEL_W'(i)) req_act = src_active_q[i];
    end

`ifdef CPLL_REFSEL_FAILOVER_EN
    logic cur_act;
    logic act_prev_q;
    logic fo_q, fo_d;
    logic cur_fell;

    always_comb begin
        cur_act = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (sel_q == SEL_W'(i)) cur_act = src_active_q[i];
    end

    assign cur_fell = act_prev_q & ~cur_act;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_prev_q <= 1'b0;
            fo_q       <= 1'b0;
        end else begin
            act_prev_q <= cur_act;
            fo_q       <= fo_d;
        end
    end

    assign failover_o = fo_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
`ifdef CPLL_REFSEL_FAILOVER_EN
        fo_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_stb_i) begin
                    if (sel_req_i == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        req_d   = sel_req_i;
                        state_d = ST_CHECK;
                    end
                end
`ifdef CPLL_REFSEL_FAILOVER_EN
                else if (cur_fell && src_active_q[FAILOVER_SEL]) begin
                    req_d   = SEL_W'(FAILOVER_SEL);
                    state_d = ST_GATE_OFF;
                    cnt_d   = '0;
                    fo_d    = 1'b1;
                end
`endif
            end
            ST_CHECK: begin
                if (!req_act) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GATE_OFF;
                    cnt_d   = '0;
                end
            end
            ST_GATE_OFF: begin
                if (cnt_q == CNT_W'(GATE_CYC - 1)) begin
                    // new select is visible during the SWITCH cycle
                    state_d = ST_SWITCH;
                    sel_d   = req_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SWITCH: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(GATE_CYC - 1)) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PLL_RST: begin
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output levels are registered functions of the next state
    always_comb begin
        gate_d = (state_d == ST_PLL_RST) || (state_d == ST_IDLE)
              || (state_d == ST_CHECK);
        prst_d = !((state_d == ST_IDLE) || (state_d == ST_CHECK));
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
            req_q   <= SEL_W'(INIT_SEL);
            sel_q   <= SEL_W'(INIT_SEL);
            gate_q  <= 1'b0;
            prst_q  <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            gate_q  <= gate_d;
            prst_q  <= prst_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign sel_cur_o    = sel_q;
    assign mux_gate_o   = gate_q;
    assign pll_rst_o    = prst_q;
    assign busy_o       = busy_q;
    assign src_active_o = src_active_q;
    assign err_dead_o   = err_q;
    assign sw_done_o    = done_q;

endmodule

// File: tb/tb_gtxe2_chnl_cpll_refsel_ctrl.sv
// Directed self-checking bench for gtxe2_chnl_cpll_refsel_ctrl.
// Default parameters; failover scenario compiled with CPLL_REFSEL_FAILOVER_EN.
module tb_gtxe2_chnl_cpll_refsel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ref_r = 8'h00;
    logic [7:0] ref_en = 8'hFF;
    logic [2:0] sel_req = 3'd0;
    logic       sel_stb = 1'b0;
    logic [2:0] sel_cur;
    logic       mux_gate;
    logic       pll_rst;
    logic       busy;
    logic [7:0] src_active;
    logic       err_dead;
    logic       sw_done;
`ifdef CPLL_REFSEL_FAILOVER_EN
    logic       failover;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;
    int viol    = 0;
    int n;

    gtxe2_chnl_cpll_refsel_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .refclk_in_i  (ref_r),
        .sel_req_i    (sel_req),
        .sel_stb_i    (sel_stb),
        .sel_cur_o    (sel_cur),
        .mux_gate_o   (mux_gate),
        .pll_rst_o    (pll_rst),
        .busy_o       (busy),
        .src_active_o (src_active),
        .err_dead_o   (err_dead),
        .sw_done_o    (sw_done)
`ifdef CPLL_REFSEL_FAILOVER_EN
        , .failover_o (failover)
`endif
    );

    always #5 clk = ~clk;
    always #17 ref_r = ref_r ^ ref_en;

    // sel_cur must never move while the mux output is enabled
    logic       prev_gate = 1'b0;
    logic [2:0] prev_sel = 3'd0;
    always @(negedge clk) begin
        if (!rst && prev_gate && mux_gate && sel_cur != prev_sel)
            viol = viol + 1;
        prev_gate = mux_gate;
        prev_sel  = sel_cur;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sig_val(input int s);
        case (s)
            0: sig_val = mux_gate;
            1: sig_val = pll_rst;
            2: sig_val = sw_done;
`ifdef CPLL_REFSEL_FAILOVER_EN
            3: sig_val = failover;
`endif
            default: sig_val = err_dead;
        endcase
    endfunction

    // Cycles until signal s reaches val; -1 if the bound expires
    task automatic wait_for(input int s, input logic val, input int max,
                            output int cyc);
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sig_val(s) == val) break;
            if (cyc >= max) begin
                cyc = -1;
                break;
            end
        end
    endtask

    // Strobe is sampled on the returned-from posedge
    task automatic strobe(input logic [2:0] req);
        @(negedge clk);
        sel_req = req;
        sel_stb = 1'b1;
        @(posedge clk);
        #1;
        sel_stb = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sel_cur", sel_cur, 1);
        check("rst_mux_gate", mux_gate, 0);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_busy", busy, 1);
        check("rst_src_active", src_active, 0);
        check("rst_err_dead", err_dead, 0);
        check("rst_sw_done", sw_done, 0);

        // power-up sequence
        rst = 1'b0;
        wait_for(0, 1'b1, 100, n);
        check("pu_settle_cyc", n, 8);
        wait_for(1, 1'b0, 100, n);
        check("pu_pllrst_cyc", n, 16);
        check("pu_sw_done", sw_done, 1);
        check("pu_busy", busy, 0);
        check("pu_sel_cur", sel_cur, 1);
        repeat (50) @(negedge clk);
        check("act_all", src_active, 8'hFE);

        // switch to source 3
        strobe(3'd3);
        check("sw3_busy", busy, 1);
        wait_for(0, 1'b0, 100, n);
        check("sw3_check_cyc", n, 1);
        wait_for(0, 1'b1, 100, n);
        check("sw3_gate_low", n, 17);
        check("sw3_sel_cur", sel_cur, 3);
        wait_for(1, 1'b0, 100, n);
        check("sw3_pllrst_cyc", n, 16);
        check("sw3_done", sw_done, 1);
        @(posedge clk);
        #1;
        check("sw3_done_pulse", sw_done, 0);

        // dead source 5
        ref_en[5] = 1'b0;
        repeat (140) @(negedge clk);
        check("act_no5", src_active, 8'hDE);
        strobe(3'd5);
        @(posedge clk);
        #1;
        check("dead5_err", err_dead, 1);
        check("dead5_sel", sel_cur, 3);
        check("dead5_gate", mux_gate, 1);
        check("dead5_pllrst", pll_rst, 0);
        check("dead5_busy", busy, 0);
        @(posedge clk);
        #1;
        check("dead5_err_pulse", err_dead, 0);

        // reserved index 0
        strobe(3'd0);
        @(posedge clk);
        #1;
        check("rsvd0_err", err_dead, 1);
        check("rsvd0_sel", sel_cur, 3);

        // request equal to current select
        strobe(3'd3);
        check("same_done", sw_done, 1);
        check("same_gate", mux_gate, 1);
        check("same_busy", busy, 0);

        // strobe during a sequence, then async reset in GATE_OFF
        strobe(3'd1);
        repeat (3) @(posedge clk);
        strobe(3'd4);
        check("mid_gate", mux_gate, 0);
        check("mid_busy", busy, 1);
        check("mid_sel", sel_cur, 3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sel", sel_cur, 1);
        check("arst_gate", mux_gate, 0);
        check("arst_pllrst", pll_rst, 1);
        check("arst_busy", busy, 1);
        check("arst_act", src_active, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_for(0, 1'b1, 100, n);
        check("rpu_settle_cyc", n, 8);
        wait_for(1, 1'b0, 100, n);
        check("rpu_pllrst_cyc", n, 16);
        check("rpu_sel", sel_cur, 1);

`ifdef CPLL_REFSEL_FAILOVER_EN
        repeat (70) @(negedge clk);
        check("fo_pre_act1", src_active[1], 1);
        ref_en[1] = 1'b0;
        wait_for(3, 1'b1, 300, n);
        check("fo_pulse_seen", n > 0, 1);
        check("fo_busy", busy, 1);
        wait_for(2, 1'b1, 100, n);
        check("fo_done_seen", n > 0, 1);
        check("fo_sel", sel_cur, 2);
        check("fo_gate", mux_gate, 1);
`endif

        check("no_sel_chg_gated", viol, 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
